// File: rtl/uart_transceiver.sv
// uart_transceiver
// Full-duplex 8N1 UART: free-running baud-enable divider, 2x-oversampling
// receiver and transmitter sharing one clock. One byte per handshake in
// each direction, no buffering.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, looking for a low level on tick2x
//   RX_START | half a bit after the falling edge, confirm start bit
//   RX_DATA  | sampling 8 data bits, LSB first, every 2nd tick2x
//   RX_STOP  | sample stop bit; good stop loads rx_data and pulses rx_valid
//   RX_WAIT  | framing error, wait for the line to return high
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | tx high, accept tx_start
//   TX_WAIT  | byte latched, waiting for the next tick1x to begin
//   TX_START | driving the start bit
//   TX_DATA  | driving data bits 0..7
//   TX_STOP  | driving the stop bit

module uart_transceiver #(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  // Half-bit period in clocks; must be at least 2 for the divider to tick.
  localparam int DIV = INPUT_CLOCK / (2 * BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  logic [CW-1:0] div_cnt;
  logic          phase;
  logic          tick2x;
  logic          tick1x;

  logic          rx_meta;
  logic          rx_sync;

  rx_state_t     rx_state;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_idx;
  logic          rx_half;

  tx_state_t     tx_state;
  logic [7:0]    tx_shift;
  logic [2:0]    tx_idx;

  assign tick2x = (div_cnt == CW'(DIV - 1));
  assign tick1x = tick2x & phase;

  // Free-running divider: tick2x every DIV clocks, phase halves it to tick1x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick2x) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous serial input; resets to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver: start detect, mid-bit sampling, stop check and output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_idx   <= '0;
      rx_half  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (tick2x && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (tick2x) begin
            if (!rx_sync) begin
              rx_state <= RX_DATA;
              rx_idx   <= '0;
              rx_half  <= 1'b0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (tick2x) begin
            if (rx_half) begin
              rx_half  <= 1'b0;
              rx_shift <= {rx_sync, rx_shift[7:1]};
              if (rx_idx == 3'd7) rx_state <= RX_STOP;
              else                rx_idx   <= rx_idx + 3'd1;
            end else begin
              rx_half <= 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick2x) begin
            if (rx_half) begin
              rx_half <= 1'b0;
              if (rx_sync) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                rx_state <= RX_IDLE;
              end else begin
                rx_state <= RX_WAIT;
              end
            end else begin
              rx_half <= 1'b1;
            end
          end
        end
        RX_WAIT: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: latch byte on accept, then one bit per tick1x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_busy  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            tx_shift <= tx_data;
            tx_busy  <= 1'b1;
            tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tick1x) begin
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tick1x) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tick1x) begin
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tick1x) begin
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: a small-divider instance (16 Hz / 1 baud, bit =
// 16 clk) checked every cycle against a timing model, plus a loopback
// instance at the default 27 MHz / 9600 parameters.

module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx;

  logic       rst_lb = 1'b1;
  logic       tx_start_lb = 1'b0;
  logic [7:0] tx_data_lb = 8'h00;
  logic [7:0] rx_data_lb;
  logic       rx_valid_lb;
  logic       tx_busy_lb;
  logic       lb_line;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_transceiver #(.INPUT_CLOCK(16), .BAUD_RATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx(tx)
  );

  uart_transceiver dut_lb (
    .clk(clk), .rst_n(rst_lb), .rx(lb_line), .rx_data(rx_data_lb), .rx_valid(rx_valid_lb),
    .tx_start(tx_start_lb), .tx_data(tx_data_lb), .tx_busy(tx_busy_lb), .tx(lb_line)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model of the small instance ----------------
  // cyc = rising edges since reset release; half-bit ticks land on cyc%8==0,
  // bit boundaries on cyc%16==0.
  int         cyc;
  logic       m_active;
  int         m_s;
  int         m_end;
  logic [7:0] m_data;
  logic [7:0] model_last;

  typedef struct {
    logic [7:0] d;
    int         lo;
    int         hi;
  } rx_exp_t;
  rx_exp_t rxq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 0;
      m_active <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_active) begin
        if (cyc + 1 == m_end) m_active <= 1'b0;
      end else if (tx_start) begin
        m_active <= 1'b1;
        m_data   <= tx_data;
        m_s      <= ((cyc + 1) / 16 + 1) * 16;
        m_end    <= ((cyc + 1) / 16 + 1) * 16 + 160;
      end
    end
  end

  always @(negedge rst_n) rxq.delete();

  function automatic logic exp_tx();
    if (!m_active || cyc < m_s) return 1'b1;
    if (cyc < m_s + 16) return 1'b0;
    if (cyc < m_s + 144) return m_data[(cyc - m_s - 16) / 16];
    return 1'b1;
  endfunction

  // Per-cycle comparison of the small instance against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_last = 8'h00;
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
    end else begin
      check("tx_line", tx, exp_tx());
      check("tx_busy", tx_busy, m_active);
      if (rx_valid) begin
        if (rxq.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 0);
        end else begin
          check("rx_valid_data", rx_data, rxq[0].d);
          check("rx_valid_in_stop", (cyc >= rxq[0].lo && cyc <= rxq[0].hi), 1);
          model_last = rxq[0].d;
          void'(rxq.pop_front());
        end
      end else if (rxq.size() > 0 && cyc > rxq[0].hi) begin
        check("rx_valid_missed", rx_valid, 1);
        void'(rxq.pop_front());
      end
      check("rx_data_hold", rx_data, model_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic align_rx();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (cyc % 8 == 5) break;
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit);
    int m;
    logic [9:0] bits;
    align_rx();
    m = cyc;
    bits = {stop_bit, d, 1'b0};
    if (stop_bit) rxq.push_back('{d, m + 144, m + 160});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int bound, output logic got, output logic [7:0] d);
    got = 1'b0;
    d = 8'h00;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        got = 1'b1;
        d = rx_data;
        break;
      end
    end
  endtask

  task automatic send_tx(input logic [7:0] d);
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = d;
    @(posedge clk);
    #1 tx_start = 1'b0;
    tx_data = ~d;
    check("tx_busy_rise", tx_busy, 1);
  endtask

  task automatic capture_tx(output logic [7:0] b);
    logic seen;
    b = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("tx_start_bit_wait");
    end else begin
      repeat (8) @(negedge clk);
      check("tx_start_bit", tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = tx;
      end
      repeat (16) @(negedge clk);
      check("tx_stop_bit", tx, 1);
    end
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) fail_now("tx_idle_wait");
  endtask

  // ---------------- directed tests on the small instance ----------------
  task automatic main_tests();
    int t2a, t2b, t1a, t1b;
    logic [7:0] b1, b2;
    logic got;
    logic [7:0] d;
    logic seen;

    #1 rst_n = 1'b0;
    #20;
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Divider spacing.
    t2a = -1; t2b = -1; t1a = -1; t1b = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut.tick2x) begin
        if (t2a < 0) t2a = cyc;
        else if (t2b < 0) t2b = cyc;
      end
      if (dut.tick1x) begin
        if (t1a < 0) t1a = cyc;
        else if (t1b < 0) t1b = cyc;
      end
    end
    check("tick2x_first", t2a, 7);
    check("tick2x_period", t2b - t2a, 8);
    check("tick1x_first", t1a, 15);
    check("tick1x_period", t1b - t1a, 16);

    // TX 0xA5 with an ignored mid-frame request.
    fork
      begin
        send_tx(8'hA5);
        repeat (60) @(posedge clk);
        #1 tx_start = 1'b1;
        tx_data = 8'hFF;
        @(posedge clk);
        #1 tx_start = 1'b0;
      end
      capture_tx(b1);
    join
    check("tx_a5_byte", b1, 8'hA5);
    wait_idle();
    repeat (40) @(negedge clk);
    check("tx_no_extra_frame", tx_busy, 0);

    // Back-to-back frames with tx_start held high.
    fork
      begin
        @(posedge clk);
        #1 tx_start = 1'b1;
        tx_data = 8'h3E;
        @(posedge clk);
        #1 tx_data = 8'h71;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (!tx_busy) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) fail_now("b2b_gap_wait");
        @(posedge clk);
        #1 tx_start = 1'b0;
        tx_data = 8'h00;
      end
      begin
        capture_tx(b1);
        capture_tx(b2);
      end
    join
    check("b2b_first", b1, 8'h3E);
    check("b2b_second", b2, 8'h71);
    wait_idle();

    // RX 0x3C then 0xFF.
    fork
      send_rx_frame(8'h3C, 1'b1);
      wait_valid(300, got, d);
    join
    check("rx_3c_valid", got, 1);
    check("rx_3c_data", d, 8'h3C);
    fork
      send_rx_frame(8'hFF, 1'b1);
      wait_valid(300, got, d);
    join
    check("rx_ff_valid", got, 1);
    check("rx_ff_data", d, 8'hFF);

    // Short glitch on idle line.
    align_rx();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    wait_valid(200, got, d);
    check("glitch_no_valid", got, 0);

    // Framing error, then a good frame.
    fork
      send_rx_frame(8'h55, 1'b0);
      wait_valid(300, got, d);
    join
    check("framing_no_valid", got, 0);
    check("framing_rx_data_kept", rx_data, 8'hFF);
    fork
      send_rx_frame(8'h12, 1'b1);
      wait_valid(300, got, d);
    join
    check("rx_12_valid", got, 1);
    check("rx_12_data", d, 8'h12);

    // Simultaneous receive and transmit.
    fork
      begin
        send_tx(8'h5A);
        capture_tx(b1);
      end
      send_rx_frame(8'hC3, 1'b1);
      wait_valid(300, got, d);
    join
    check("dup_tx_byte", b1, 8'h5A);
    check("dup_rx_valid", got, 1);
    check("dup_rx_data", d, 8'hC3);
    wait_idle();

    // Reset during TX bit 3.
    send_tx(8'hC6);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("rst_frame_start_wait");
    repeat (72) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_valid", rx_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    fork
      send_tx(8'h96);
      capture_tx(b1);
    join
    check("post_rst_tx_byte", b1, 8'h96);
    wait_idle();
    repeat (20) @(posedge clk);
  endtask

  // ---------------- loopback at default parameters ----------------
  task automatic loopback_tests();
    logic [7:0] lb_bytes[3] = '{8'h00, 8'hFF, 8'h81};
    logic ok;
    #1 rst_lb = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_lb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 6000; k++) begin
        @(negedge clk);
        if (!tx_busy_lb) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("lb_idle_wait");
      @(posedge clk);
      #1 tx_start_lb = 1'b1;
      tx_data_lb = lb_bytes[i];
      @(posedge clk);
      #1 tx_start_lb = 1'b0;
      tx_data_lb = 8'h5A;
      ok = 1'b0;
      for (int k = 0; k < 40000; k++) begin
        @(negedge clk);
        if (rx_valid_lb) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now("lb_valid_wait");
      else check("lb_byte", rx_data_lb, lb_bytes[i]);
    end
  endtask

  initial begin
    fork
      main_tests();
      loopback_tests();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
